// File: rtl/frame_sync_controller.sv
// Frame-alignment controller for LSB-first serial streams framed by a 4-bit sync word.
// Hunts for the sync word, confirms it over several frames, then tracks frames and extracts payload bits.
module frame_sync_controller #(
    parameter logic [3:0] SYNC_CODE   = 4'b1001,
    parameter int         PAYLOAD_LEN = 8,
    parameter int         CONFIRM_N   = 2,
    parameter int         MISS_N      = 3,
    parameter int         CNT_W       = 8
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       data,
    input  logic       data_valid,
    output logic       payload_bit,
    output logic       payload_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err,
    output logic [1:0] state
);

    localparam int FRAME_LEN = PAYLOAD_LEN + 4;
    localparam int CONF_W    = (CONFIRM_N > 1) ? $clog2(CONFIRM_N) : 1;
    localparam int MISS_W    = (MISS_N > 1) ? $clog2(MISS_N) : 1;

    localparam logic [CNT_W-1:0]  CHECK_POS = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  PAY_END   = CNT_W'(PAYLOAD_LEN);
    localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_N - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_N - 1);

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        VERIFY   = 2'd1,
        LOCKED   = 2'd2,
        FLYWHEEL = 2'd3
    } state_t;

    state_t              r_state;
    // Only the three newest bits of the sync window are kept; the oldest one
    // is shifted out on the very beat it would be compared, so it is never read.
    logic [2:0]          r_sr_hi;
    logic [CNT_W-1:0]    r_pos;
    logic [CONF_W-1:0]   r_confirm_cnt;
    logic [MISS_W-1:0]   r_miss_cnt;
    logic                r_payload_bit;
    logic                r_payload_valid;
    logic                r_frame_start;
    logic                r_sync_err;
    logic                r_locked;

    state_t              w_state_next;
    logic [CNT_W-1:0]    w_pos_next;
    logic [CONF_W-1:0]   w_confirm_next;
    logic [MISS_W-1:0]   w_miss_next;
    logic                w_emit;
    logic                w_sync_err_next;
    logic                w_match;
    logic                w_check;

    // The current beat is treated as the last sync bit.
    assign w_match = ({data, r_sr_hi} == SYNC_CODE);
    assign w_check = (r_pos == CHECK_POS);

    always_comb begin
        w_state_next    = r_state;
        w_pos_next      = r_pos;
        w_confirm_next  = r_confirm_cnt;
        w_miss_next     = r_miss_cnt;
        w_emit          = 1'b0;
        w_sync_err_next = 1'b0;
        if (data_valid) begin
            case (r_state)
                HUNT: begin
                    if (w_match) begin
                        w_state_next   = VERIFY;
                        w_pos_next     = '0;
                        w_confirm_next = '0;
                    end
                end
                VERIFY: begin
                    if (w_check) begin
                        w_pos_next = '0;
                        if (w_match) begin
                            if (r_confirm_cnt == CONF_LAST) begin
                                w_state_next = LOCKED;
                                w_miss_next  = '0;
                            end else begin
                                w_confirm_next = r_confirm_cnt + CONF_W'(1);
                            end
                        end else begin
                            w_state_next = HUNT;
                        end
                    end else begin
                        w_pos_next = r_pos + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (w_check) begin
                        w_pos_next = '0;
                        if (!w_match) begin
                            w_sync_err_next = 1'b1;
                            if (MISS_N == 1) begin
                                w_state_next = HUNT;
                            end else begin
                                w_state_next = FLYWHEEL;
                                w_miss_next  = MISS_W'(1);
                            end
                        end
                    end else begin
                        w_pos_next = r_pos + CNT_W'(1);
                        w_emit     = (r_pos < PAY_END);
                    end
                end
                FLYWHEEL: begin
                    if (w_check) begin
                        w_pos_next = '0;
                        if (w_match) begin
                            w_state_next = LOCKED;
                            w_miss_next  = '0;
                        end else begin
                            w_sync_err_next = 1'b1;
                            if (r_miss_cnt == MISS_LAST) begin
                                w_state_next = HUNT;
                                w_miss_next  = '0;
                            end else begin
                                w_miss_next = r_miss_cnt + MISS_W'(1);
                            end
                        end
                    end else begin
                        w_pos_next = r_pos + CNT_W'(1);
                        w_emit     = (r_pos < PAY_END);
                    end
                end
                default: begin
                    w_state_next = HUNT;
                    w_pos_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state         <= HUNT;
            r_sr_hi         <= '0;
            r_pos           <= '0;
            r_confirm_cnt   <= '0;
            r_miss_cnt      <= '0;
            r_payload_bit   <= 1'b0;
            r_payload_valid <= 1'b0;
            r_frame_start   <= 1'b0;
            r_sync_err      <= 1'b0;
            r_locked        <= 1'b0;
        end else begin
            if (data_valid) begin
                r_sr_hi <= {data, r_sr_hi[2:1]};
            end
            if (w_emit) begin
                r_payload_bit <= data;
            end
            r_state         <= w_state_next;
            r_pos           <= w_pos_next;
            r_confirm_cnt   <= w_confirm_next;
            r_miss_cnt      <= w_miss_next;
            r_payload_valid <= w_emit;
            r_frame_start   <= w_emit && (r_pos == '0);
            r_sync_err      <= w_sync_err_next;
            r_locked        <= (w_state_next == LOCKED) || (w_state_next == FLYWHEEL);
        end
    end

    assign payload_bit   = r_payload_bit;
    assign payload_valid = r_payload_valid;
    assign frame_start   = r_frame_start;
    assign locked        = r_locked;
    assign sync_err      = r_sync_err;
    assign state         = r_state;

endmodule

// File: tb/tb_frame_sync_controller.sv
// Bench for frame_sync_controller: directed scenarios plus randomized framed traffic,
// every cycle compared against a beat-level reference model.
module tb_frame_sync_controller;

    localparam int PL = 8;
    localparam int FL = PL + 4;
    localparam int CN = 2;
    localparam int MN = 3;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       data = 1'b0;
    logic       data_valid = 1'b0;
    logic       payload_bit;
    logic       payload_valid;
    logic       frame_start;
    logic       locked;
    logic       sync_err;
    logic [1:0] state;

    frame_sync_controller dut (
        .clk          (clk),
        .Reset        (Reset),
        .data         (data),
        .data_valid   (data_valid),
        .payload_bit  (payload_bit),
        .payload_valid(payload_valid),
        .frame_start  (frame_start),
        .locked       (locked),
        .sync_err     (sync_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0..3 = hunt/verify/locked/flywheel.
    bit [3:0] sync_v = 4'b1001;
    bit       hist_q[$];
    int       m_mode, m_since, m_hits, m_miss;
    bit       m_pv, m_fs, m_se, m_pb;

    function automatic void model_step(bit rst_n, bit v, bit d);
        bit m;
        if (!rst_n) begin
            m_mode = 0; m_since = 0; m_hits = 0; m_miss = 0;
            hist_q = '{1'b0, 1'b0, 1'b0};
            m_pv = 0; m_fs = 0; m_se = 0; m_pb = 0;
            return;
        end
        m_pv = 0; m_fs = 0; m_se = 0;
        if (!v) return;
        m = (hist_q[0] == sync_v[0]) && (hist_q[1] == sync_v[1]) &&
            (hist_q[2] == sync_v[2]) && (d == sync_v[3]);
        hist_q.push_back(d);
        void'(hist_q.pop_front());
        case (m_mode)
            0: if (m) begin m_mode = 1; m_since = 0; m_hits = 0; end
            1: begin
                if (m_since == FL - 1) begin
                    if (m) begin
                        m_since = 0;
                        m_hits++;
                        if (m_hits == CN) begin m_mode = 2; m_miss = 0; end
                    end else begin
                        m_mode = 0;
                    end
                end else begin
                    m_since++;
                end
            end
            default: begin
                if (m_since == FL - 1) begin
                    m_since = 0;
                    if (m) begin
                        m_mode = 2; m_miss = 0;
                    end else begin
                        m_se = 1;
                        m_miss++;
                        m_mode = (m_miss >= MN) ? 0 : 3;
                    end
                end else begin
                    if (m_since < PL) begin
                        m_pv = 1; m_pb = d; m_fs = (m_since == 0);
                    end
                    m_since++;
                end
            end
        endcase
    endfunction

    bit cap_q[$];
    int fs_q[$];
    int se_cnt;

    task automatic cyc(bit rst_n, bit v, bit d);
        @(negedge clk);
        Reset = rst_n; data_valid = v; data = d;
        @(posedge clk);
        model_step(rst_n, v, d);
        #1;
        chk("state", 32'(state), 32'(m_mode));
        chk("locked", 32'(locked), (m_mode >= 2) ? 32'd1 : 32'd0);
        chk("payload_valid", 32'(payload_valid), 32'(m_pv));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("sync_err", 32'(sync_err), 32'(m_se));
        chk("payload_bit", 32'(payload_bit), 32'(m_pb));
        if (payload_valid === 1'b1) begin
            if (frame_start === 1'b1) fs_q.push_back(cap_q.size());
            cap_q.push_back(payload_bit);
        end
        if (sync_err === 1'b1) se_cnt++;
    endtask

    task automatic beat(bit d, int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) cyc(1'b1, 1'b0, 1'($urandom));
        cyc(1'b1, 1'b1, d);
    endtask

    task automatic send_sync(logic [3:0] sw, int maxgap);
        for (int i = 0; i < 4; i++) beat(sw[i], maxgap);
    endtask

    task automatic send_pay(logic [7:0] p, int maxgap);
        for (int i = 0; i < PL; i++) beat(p[i], maxgap);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0);
        cap_q.delete();
        fs_q.delete();
        se_cnt = 0;
    endtask

    logic [7:0] pays [6];

    task automatic run_clean(int maxgap, string tag);
        do_reset();
        for (int f = 0; f < 6; f++) begin
            send_sync(4'b1001, maxgap);
            if (f == 0) chk({tag, "_verify_after_first_hit"}, 32'(state), 32'd1);
            if (f == 1) chk({tag, "_verify_after_second_hit"}, 32'(state), 32'd1);
            if (f == 2) chk({tag, "_locked_after_third_hit"}, 32'(state), 32'd2);
            send_pay(pays[f], maxgap);
        end
        chk({tag, "_pay_count"}, 32'(cap_q.size()), 32'd32);
        for (int k = 0; k < 32 && k < cap_q.size(); k++)
            chk({tag, "_pay_bit"}, 32'(cap_q[k]), 32'(pays[2 + k / 8][k % 8]));
        chk({tag, "_fs_count"}, 32'(fs_q.size()), 32'd4);
        for (int j = 0; j < fs_q.size(); j++)
            chk({tag, "_fs_pos"}, 32'(fs_q[j]), 32'(8 * j));
    endtask

    task automatic lock_up();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            send_sync(4'b1001, 0);
            send_pay(8'($urandom), 0);
        end
    endtask

    initial begin
        int sz;
        int r;
        logic [3:0] sw;

        for (int f = 0; f < 6; f++) pays[f] = 8'($urandom);

        // Reset state
        do_reset();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_payload_valid", 32'(payload_valid), 32'd0);

        // Clean frames, then the same frames with idle gaps
        run_clean(0, "clean");
        run_clean(3, "gaps");

        // False sync followed by a missing sync at the check beat
        do_reset();
        send_sync(4'b0110, 0);
        send_sync(4'b1001, 0);
        chk("false_verify", 32'(state), 32'd1);
        for (int i = 0; i < FL - 1; i++) beat(1'b0, 0);
        chk("false_still_verify", 32'(state), 32'd1);
        beat(1'b0, 0);
        chk("false_back_to_hunt", 32'(state), 32'd0);
        chk("false_no_payload", 32'(cap_q.size()), 32'd0);

        // Flywheel recovery
        lock_up();
        send_sync(4'b0000, 0);
        chk("fly_state", 32'(state), 32'd3);
        chk("fly_err_count", 32'(se_cnt), 32'd1);
        send_pay(8'($urandom), 0);
        send_sync(4'b1001, 0);
        chk("fly_relock", 32'(state), 32'd2);
        chk("fly_payload_continuous", 32'(cap_q.size()), 32'd16);
        send_pay(8'($urandom), 0);

        // Loss of lock after MN consecutive misses
        se_cnt = 0;
        send_sync(4'b0000, 0);
        send_pay(8'($urandom), 0);
        send_sync(4'b0000, 0);
        chk("loss_second_miss_flywheel", 32'(state), 32'd3);
        send_pay(8'($urandom), 0);
        send_sync(4'b0000, 0);
        chk("loss_hunt", 32'(state), 32'd0);
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_err_count", 32'(se_cnt), 32'd3);
        sz = cap_q.size();
        send_pay(8'($urandom), 0);
        chk("loss_no_payload", 32'(cap_q.size()), 32'(sz));

        // Reset mid-frame at pos 5 while locked
        lock_up();
        send_sync(4'b1001, 0);
        for (int i = 0; i < 5; i++) beat(1'($urandom), 0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("midreset_state", 32'(state), 32'd0);
        chk("midreset_valid", 32'(payload_valid), 32'd0);
        chk("midreset_locked", 32'(locked), 32'd0);
        cap_q.delete();
        for (int f = 0; f < 3; f++) begin
            send_sync(4'b1001, 0);
            if (f == 2) chk("midreset_relock", 32'(state), 32'd2);
            send_pay(8'($urandom), 0);
        end
        chk("midreset_relock_payload", 32'(cap_q.size()), 32'd8);

        // Randomized framed traffic with corrupted syncs, noise and resets
        do_reset();
        for (int it = 0; it < 150; it++) begin
            r = int'($urandom_range(19, 0));
            if (r == 0) begin
                for (int i = 0; i < FL; i++) beat(1'($urandom), 3);
            end else if (r == 1) begin
                cyc(1'b0, 1'($urandom), 1'($urandom));
            end else begin
                sw = ($urandom_range(5, 0) == 0) ? 4'($urandom) : 4'b1001;
                send_sync(sw, 3);
                send_pay(8'($urandom), 3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
